// File: rtl/neuron_mac_accumulator_if.sv
// Stream bus between the neuron MAC stage and its neighbours: (input, weight) beats
// in, rounded Q5.11 sum plus activation select out.
interface neuron_mac_accumulator_if #(
    parameter int DATAWIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] in_data;
    logic [DATAWIDTH-1:0] weight;
    logic                 in_last;
    logic                 func_sel;
    logic [DATAWIDTH-1:0] bias;
    logic [DATAWIDTH-1:0] sum;
    logic                 activation_func;
    logic                 sum_valid;
    logic                 sum_ready;
    logic                 sat_flag;
    logic                 len_err;

    modport slave (
        input  in_valid, in_data, weight, in_last, func_sel, bias, sum_ready,
        output in_ready, sum, activation_func, sum_valid, sat_flag, len_err
    );

    modport master (
        output in_valid, in_data, weight, in_last, func_sel, bias, sum_ready,
        input  in_ready, sum, activation_func, sum_valid, sat_flag, len_err
    );
endinterface

// File: rtl/neuron_mac_accumulator.sv
// Per-neuron MAC: product pipeline, 40-bit accumulate, round-half-up and saturate to Q5.11.
// Optional bias add into the accumulator is enabled by defining NEURON_BIAS_EN.
module neuron_mac_accumulator #(
    parameter int DATAWIDTH  = 16,
    parameter int FRAC_IN    = 11,
    parameter int FRAC_W     = 14,
    parameter int ACCWIDTH   = 40,
    parameter int MAX_INPUTS = 256
) (
    input  logic                     clock,
    input  logic                     reset_n,
    neuron_mac_accumulator_if.slave  bus
);
    localparam int CNTW  = $clog2(MAX_INPUTS) + 1;
    localparam int PRODW = 2 * DATAWIDTH;
    localparam logic signed [ACCWIDTH-1:0] HALF    = ACCWIDTH'(2 ** (FRAC_W - 1));
    localparam logic signed [ACCWIDTH-1:0] SUM_MAX = ACCWIDTH'((2 ** (DATAWIDTH - 1)) - 1);
    localparam logic signed [ACCWIDTH-1:0] SUM_MIN = -SUM_MAX - ACCWIDTH'(1);

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, FINAL, HOLD} state_t;

    state_t                       state_q;
    logic                         in_ready_q;
    logic [CNTW-1:0]              cnt_q;
    logic signed [PRODW-1:0]      prod_q, prod_d;
    logic                         p1_valid_q, p1_last_q, p2_last_q;
    logic signed [ACCWIDTH-1:0]   acc_q, acc_d, rnd_d;
    logic [DATAWIDTH-1:0]         sum_q, sum_d;
    logic                         clip_d;
    logic                         func_q, sum_valid_q, sat_q, len_err_q;
    logic                         beat, at_max, last_eff;

    assign beat     = bus.in_valid && in_ready_q;
    assign at_max   = (cnt_q == CNTW'(MAX_INPUTS - 1));
    assign last_eff = bus.in_last || at_max;
    assign prod_d   = PRODW'($signed(bus.in_data)) * PRODW'($signed(bus.weight));

`ifdef NEURON_BIAS_EN
    logic [DATAWIDTH-1:0]       bias_q;
    logic signed [ACCWIDTH-1:0] bias_ext;
    // Accumulator carries FRAC_IN+FRAC_W fraction bits, so Q5.11 bias aligns by FRAC_W.
    assign bias_ext = $signed({{(ACCWIDTH-DATAWIDTH){bias_q[DATAWIDTH-1]}}, bias_q}) <<< FRAC_W;
`else
    logic unused_bias;
    assign unused_bias = ^bus.bias;
`endif

    always_comb begin
        acc_d = acc_q;
        if (p1_valid_q) begin
            acc_d = acc_q + $signed({{(ACCWIDTH-PRODW){prod_q[PRODW-1]}}, prod_q});
`ifdef NEURON_BIAS_EN
            if (p1_last_q) acc_d = acc_d + bias_ext;
`endif
        end
    end

    always_comb begin
        rnd_d  = (acc_q + HALF) >>> FRAC_W;
        clip_d = 1'b0;
        sum_d  = rnd_d[DATAWIDTH-1:0];
        if (rnd_d > SUM_MAX) begin
            sum_d  = SUM_MAX[DATAWIDTH-1:0];
            clip_d = 1'b1;
        end else if (rnd_d < SUM_MIN) begin
            sum_d  = SUM_MIN[DATAWIDTH-1:0];
            clip_d = 1'b1;
        end
    end

    // in_ready is registered: it stays low through reset and for one cycle after HOLD.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            cnt_q       <= '0;
            prod_q      <= '0;
            p1_valid_q  <= 1'b0;
            p1_last_q   <= 1'b0;
            p2_last_q   <= 1'b0;
            acc_q       <= '0;
            sum_q       <= '0;
            func_q      <= 1'b0;
            sum_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            len_err_q   <= 1'b0;
`ifdef NEURON_BIAS_EN
            bias_q      <= '0;
`endif
        end else begin
            p1_valid_q <= beat;
            p1_last_q  <= beat && last_eff;
            p2_last_q  <= p1_valid_q && p1_last_q;
            if (beat) prod_q <= prod_d;
            acc_q <= acc_d;
`ifdef NEURON_BIAS_EN
            if (beat && last_eff) bias_q <= bus.bias;
`endif
            case (state_q)
                IDLE: begin
                    in_ready_q <= !(beat && last_eff);
                    if (beat) begin
                        acc_q   <= '0;
                        func_q  <= bus.func_sel;
                        cnt_q   <= CNTW'(1);
                        state_q <= bus.in_last ? DRAIN : ACCUM;
                    end
                end
                ACCUM: begin
                    in_ready_q <= !(beat && last_eff);
                    if (beat) begin
                        cnt_q <= cnt_q + CNTW'(1);
                        if (last_eff) begin
                            state_q <= DRAIN;
                            if (!bus.in_last) len_err_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    in_ready_q <= 1'b0;
                    if (p2_last_q) state_q <= FINAL;
                end
                FINAL: begin
                    in_ready_q  <= 1'b0;
                    sum_q       <= sum_d;
                    sat_q       <= clip_d;
                    sum_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    in_ready_q <= 1'b0;
                    if (bus.sum_ready) begin
                        sum_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    in_ready_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.sum             = sum_q;
    assign bus.activation_func = func_q;
    assign bus.sum_valid       = sum_valid_q;
    assign bus.sat_flag        = sat_q;
    assign bus.len_err         = len_err_q;
endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Scoreboard bench for neuron_mac_accumulator: directed vectors with hand-computed results.
module tb_neuron_mac_accumulator;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    neuron_mac_accumulator_if #(.DATAWIDTH(16)) bus ();

    neuron_mac_accumulator #(
        .DATAWIDTH(16), .FRAC_IN(11), .FRAC_W(14), .ACCWIDTH(40), .MAX_INPUTS(256)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [15:0] sum;
        logic        func;
        logic        sat;
        logic        lerr;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_drive_cyc = 0;
    int   hold_cycles = 0;
    logic lerr_exp = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send_beat(input logic [15:0] d, input logic [15:0] w, input logic [15:0] b,
                             input logic last, input logic fs, input int bubbles);
        int t;
        repeat (bubbles) @(negedge clock);
        t = 0;
        while (!bus.in_ready && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (t >= 200) chk("in_ready_timeout", 32'd0, 32'd1);
        bus.in_data  = d;
        bus.weight   = w;
        bus.bias     = b;
        bus.in_last  = last;
        bus.func_sel = fs;
        bus.in_valid = 1'b1;
        last_drive_cyc = cyc;
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_vec(input int n, input logic [15:0] d, input logic [15:0] w,
                            input logic [15:0] b, input logic fs, input int bub,
                            input logic use_last, input logic [15:0] es, input logic esat);
        exp_t e;
        for (int i = 0; i < n; i++)
            send_beat(d, w, b, use_last && (i == n - 1), fs, (i == 0) ? 0 : bub);
        e.sum = es; e.func = fs; e.sat = esat; e.lerr = lerr_exp; e.acc_cyc = last_drive_cyc;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((sb.size() != 0 || bus.sum_valid) && t < 2000) begin
            @(negedge clock);
            t++;
        end
        if (t >= 2000) chk("drain_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clock);
    endtask

    // Monitor: compare each new result against the oldest expectation.
    initial begin
        logic sv_prev;
        exp_t e;
        sv_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (reset_n && bus.sum_valid && !sv_prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_sum", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sum", bus.sum, e.sum);
                    chk("activation_func", bus.activation_func, e.func);
                    chk("sat_flag", bus.sat_flag, e.sat);
                    chk("len_err", bus.len_err, e.lerr);
                    chk("latency", cyc - e.acc_cyc, 32'd4);
                end
            end
            sv_prev = reset_n && bus.sum_valid;
        end
    end

    // Sink: optionally stall, then accept with a one-cycle sum_ready pulse.
    initial begin
        logic [15:0] s;
        logic        f;
        logic        sat;
        int          h;
        forever begin
            @(negedge clock);
            if (reset_n && bus.sum_valid) begin
                s = bus.sum; f = bus.activation_func; sat = bus.sat_flag; h = hold_cycles;
                for (int i = 0; i < h; i++) begin
                    @(negedge clock);
                    chk("hold_sum_stable", bus.sum, s);
                    chk("hold_func_stable", bus.activation_func, f);
                    chk("hold_sat_stable", bus.sat_flag, sat);
                    chk("hold_valid", bus.sum_valid, 1'b1);
                    chk("hold_in_ready", bus.in_ready, 1'b0);
                end
                bus.sum_ready = 1'b1;
                @(negedge clock);
                bus.sum_ready = 1'b0;
                chk("valid_drop", bus.sum_valid, 1'b0);
                chk("ready_after_drop", bus.in_ready, 1'b0);
                @(negedge clock);
                chk("ready_rise", bus.in_ready, 1'b1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
        chk({tag, "_sum"}, bus.sum, 16'h0000);
        chk({tag, "_func"}, bus.activation_func, 1'b0);
        chk({tag, "_sum_valid"}, bus.sum_valid, 1'b0);
        chk({tag, "_sat"}, bus.sat_flag, 1'b0);
        chk({tag, "_len_err"}, bus.len_err, 1'b0);
    endtask

    localparam logic [15:0] BIAS_SUM =
`ifdef NEURON_BIAS_EN
        16'h0C00;
`else
        16'h0400;
`endif

    typedef struct {
        logic [15:0] d;
        logic [15:0] w;
        logic [15:0] es;
        logic        esat;
    } vec_t;

    vec_t singles[6] = '{
        '{16'h8000, 16'h8000, 16'h7FFF, 1'b1},   // +2.0^... full-scale product clips high
        '{16'h8000, 16'h7FFF, 16'h8000, 1'b1},   // most negative product clips low
        '{16'h0800, 16'hE000, 16'hFC00, 1'b0},   // 1.0 * -0.5 = -0.5
        '{16'h0001, 16'h2000, 16'h0001, 1'b0},   // exactly half LSB rounds up
        '{16'h0001, 16'hE000, 16'h0000, 1'b0},   // minus half LSB rounds up to 0
        '{16'h0800, 16'hFFFF, 16'h0000, 1'b0}    // tiny negative rounds to 0
    };

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.weight = '0; bus.in_last = 1'b0;
        bus.func_sel = 1'b0; bus.bias = '0; bus.sum_ready = 1'b0;
        repeat (3) @(negedge clock);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        @(negedge clock);
        chk("ready_after_reset", bus.in_ready, 1'b1);

        send_vec(1, 16'h0800, 16'h2000, 16'h0000, 1'b0, 0, 1'b1, 16'h0400, 1'b0);
        wait_done();
        send_vec(3, 16'h0800, 16'h2000, 16'h0000, 1'b1, 3, 1'b1, 16'h0C00, 1'b0);
        wait_done();
        send_vec(20, 16'h7FFF, 16'h4000, 16'h0000, 1'b0, 0, 1'b1, 16'h7FFF, 1'b1);
        wait_done();
        send_vec(20, 16'h7FFF, 16'hC000, 16'h0000, 1'b1, 0, 1'b1, 16'h8000, 1'b1);
        wait_done();
        for (int i = 0; i < 6; i++) begin
            send_vec(1, singles[i].d, singles[i].w, 16'h0000, i[0], 0, 1'b1,
                     singles[i].es, singles[i].esat);
            wait_done();
        end

        hold_cycles = 10;
        send_vec(1, 16'h0800, 16'h2000, 16'h0000, 1'b1, 0, 1'b1, 16'h0400, 1'b0);
        wait_done();
        hold_cycles = 0;

        send_vec(1, 16'h0800, 16'h2000, 16'h0800, 1'b0, 0, 1'b1, BIAS_SUM, 1'b0);
        wait_done();

        lerr_exp = 1'b1;
        send_vec(256, 16'h0800, 16'h0008, 16'h0000, 1'b0, 0, 1'b0, 16'h0100, 1'b0);
        wait_done();
        send_vec(1, 16'h0800, 16'h2000, 16'h0000, 1'b1, 0, 1'b1, 16'h0400, 1'b0);
        wait_done();

        for (int i = 0; i < 2; i++) send_beat(16'h7FFF, 16'h4000, 16'h0000, 1'b0, 1'b1, 0);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (2) @(negedge clock);
        check_outputs_zero("midreset_hold");
        reset_n = 1'b1;
        lerr_exp = 1'b0;
        @(negedge clock);
        send_vec(1, 16'h0800, 16'h2000, 16'h0000, 1'b0, 0, 1'b1, 16'h0400, 1'b0);
        wait_done();

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
